// File: rtl/riscv_irq_controller_mc.sv
// Multi-line interrupt controller: arbitrates IRQ_NUM level requests, raises a one-cycle trap
// with mcause, acks the granted line, and tracks in-service state until mret. IRQ_RR_EN selects round-robin.
module riscv_irq_controller_mc #(
  parameter int IRQ_NUM    = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [IRQ_NUM-1:0] mie_i,
  input  logic               gie_i,
  input  logic               exception_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic               irq_ret_o,
  output logic               busy_o
);

  localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef enum logic {
    IDLE,
    SERVICE
  } state_e;

  state_e             state_q, state_d;
  logic [IRQ_NUM-1:0] elig;
  logic [IRQ_NUM-1:0] ack_q;
  logic [IDX_W-1:0]   win_idx;
  logic [31:0]        cause_q;
  logic [31:0]        take_cause;
  logic               take;
  logic               ret;

  assign elig       = irq_req_i & mie_i;
  assign take_cause = {1'b1, 31'(CAUSE_BASE) + 31'(win_idx)};

`ifdef IRQ_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] rr_idx;
  int               rr_sum;

  // Search from ptr_q upward with wrap; descending offsets so the nearest line wins.
  always_comb begin
    win_idx = '0;
    rr_idx  = '0;
    rr_sum  = 0;
    for (int off = IRQ_NUM - 1; off >= 0; off--) begin
      rr_sum = int'(ptr_q) + off;
      if (rr_sum >= IRQ_NUM) rr_sum = rr_sum - IRQ_NUM;
      rr_idx = IDX_W'(rr_sum);
      if (elig[rr_idx]) win_idx = rr_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win_idx == IDX_W'(IRQ_NUM - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  // Take and return are also gated by rst_i so no pulse escapes while reset is held.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    ret     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_i && gie_i && !stall_i && !exception_i && (|elig)) begin
          take    = 1'b1;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (rst_i && mret_i && !stall_i) begin
          ret     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ack_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= take ? (IRQ_NUM'(1) << win_idx) : '0;
      if (take) cause_q <= take_cause;
    end
  end

  assign irq_o       = take;
  assign irq_ret_o   = ret;
  assign irq_cause_o = take ? take_cause : cause_q;
  assign irq_ack_o   = ack_q;
  assign busy_o      = (state_q == SERVICE);

endmodule

// File: tb/tb_riscv_irq_controller_mc.sv
// Self-checking bench for riscv_irq_controller_mc: directed steps plus random cycles checked
// every cycle against a behavioural model of the arbitration and service rules.
module tb_riscv_irq_controller_mc;

  localparam int IRQ_NUM    = 16;
  localparam int CAUSE_BASE = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               stall_i;
  logic [IRQ_NUM-1:0] irq_req_i;
  logic [IRQ_NUM-1:0] mie_i;
  logic               gie_i;
  logic               exception_i;
  logic               mret_i;
  logic               irq_o;
  logic [31:0]        irq_cause_o;
  logic [IRQ_NUM-1:0] irq_ack_o;
  logic               irq_ret_o;
  logic               busy_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit                 m_busy  = 1'b0;
  logic [IRQ_NUM-1:0] m_ack   = '0;
  logic [31:0]        m_cause = '0;
  int                 m_ptr   = 0;

  riscv_irq_controller_mc #(
    .IRQ_NUM    (IRQ_NUM),
    .CAUSE_BASE (CAUSE_BASE)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .gie_i       (gie_i),
    .exception_i (exception_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o),
    .irq_ret_o   (irq_ret_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [IRQ_NUM-1:0] e, input int start);
    for (int n = 0; n < IRQ_NUM; n++) begin
      int line;
      line = (start + n) % IRQ_NUM;
      if (e[line]) return line;
    end
    return -1;
  endfunction

  // Called just after a negedge with inputs set: checks all outputs, advances one clock.
  task automatic step(input string tag);
    logic [IRQ_NUM-1:0] e;
    logic [31:0]        exp_cause;
    int                 k;
    int                 start;
    bit                 can_take;
    bit                 can_ret;
    #1;
`ifdef IRQ_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    e         = irq_req_i & mie_i;
    k         = pick(e, start);
    can_take  = rst_i && !m_busy && gie_i && !stall_i && !exception_i && (k >= 0);
    can_ret   = rst_i && m_busy && mret_i && !stall_i;
    exp_cause = can_take ? {1'b1, 31'(CAUSE_BASE + k)} : m_cause;
    check({tag, ".irq"},   32'(irq_o),     32'(can_take));
    check({tag, ".ret"},   32'(irq_ret_o), 32'(can_ret));
    check({tag, ".cause"}, irq_cause_o,    exp_cause);
    check({tag, ".busy"},  32'(busy_o),    32'(m_busy));
    check({tag, ".ack"},   32'(irq_ack_o), 32'(m_ack));
    @(posedge clk_i);
    if (!rst_i) begin
      m_busy  = 1'b0;
      m_ack   = '0;
      m_cause = '0;
      m_ptr   = 0;
    end else begin
      m_ack = '0;
      if (can_take) begin
        m_ack[k] = 1'b1;
        m_busy   = 1'b1;
        m_cause  = exp_cause;
        m_ptr    = (k + 1) % IRQ_NUM;
      end else if (can_ret) begin
        m_busy = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_i       = 1'b0;
    stall_i     = 1'b0;
    irq_req_i   = '0;
    mie_i       = '0;
    gie_i       = 1'b0;
    exception_i = 1'b0;
    mret_i      = 1'b0;
    @(negedge clk_i);
    step("rst0");
    step("rst1");
    rst_i = 1'b1;

    // Single line 3
    irq_req_i = 16'h0008; mie_i = 16'h0008; gie_i = 1'b1;
    #1 check("a.irq", 32'(irq_o), 32'd1);
    check("a.cause", irq_cause_o, 32'h8000_0013);
    step("a_take");
    #1 check("a.ack", 32'(irq_ack_o), 32'h0008);
    check("a.busy", 32'(busy_o), 32'd1);
    step("a_svc");
    #1 check("a.ack_once", 32'(irq_ack_o), 32'h0);
    mret_i = 1'b1;
    #1 check("a.ret", 32'(irq_ret_o), 32'd1);
    step("a_mret");
    mret_i = 1'b0; irq_req_i = '0;
    #1 check("a.idle", 32'(busy_o), 32'd0);
    step("a_idle");

    // Lines 2 and 5 together
    irq_req_i = 16'h0024; mie_i = 16'hFFFF;
`ifndef IRQ_RR_EN
    #1 check("b.cause2", irq_cause_o, 32'h8000_0012);
`endif
    step("b_take");
    irq_req_i = 16'h0020; mret_i = 1'b1;
    step("b_mret");
    mret_i = 1'b0;
`ifndef IRQ_RR_EN
    #1 check("b.irq5", 32'(irq_o), 32'd1);
    check("b.cause5", irq_cause_o, 32'h8000_0015);
`endif
    step("b_take5");
    mret_i = 1'b1; irq_req_i = '0;
    step("b_mret5");
    mret_i = 1'b0;
    step("b_idle");

    // Exception blocks the take for one cycle
    irq_req_i = 16'h0010; mie_i = 16'h0010; exception_i = 1'b1;
    #1 check("c.exc_irq", 32'(irq_o), 32'd0);
    step("c_exc");
    exception_i = 1'b0;
    #1 check("c.irq", 32'(irq_o), 32'd1);
    check("c.cause", irq_cause_o, 32'h8000_0014);
    step("c_take");

    // New request in service, stalled mret, then release
    irq_req_i = 16'h0090; mie_i = 16'h0090;
    #1 check("d.no_nest", 32'(irq_o), 32'd0);
    step("d_svc");
    irq_req_i = 16'h0080; mret_i = 1'b1; stall_i = 1'b1;
    #1 check("d.stall_ret", 32'(irq_ret_o), 32'd0);
    step("d_stall");
    #1 check("d.stall_busy", 32'(busy_o), 32'd1);
    stall_i = 1'b0;
    #1 check("d.ret", 32'(irq_ret_o), 32'd1);
    step("d_mret");
    mret_i = 1'b0;
    #1 check("d.irq7", 32'(irq_o), 32'd1);
    check("d.cause7", irq_cause_o, 32'h8000_0017);
    step("d_take7");
    mret_i = 1'b1; irq_req_i = '0;
    step("d_mret7");
    mret_i = 1'b0;
    step("d_idle");

    // Masked by mie and by gie; mret in IDLE
    irq_req_i = 16'hFFFF; mie_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1 check("e.mie_irq", 32'(irq_o), 32'd0);
      step("e_mie");
    end
    mie_i = 16'hFFFF; gie_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("e.gie_irq", 32'(irq_o), 32'd0);
      step("e_gie");
    end
    mret_i = 1'b1;
    #1 check("e.idle_ret", 32'(irq_ret_o), 32'd0);
    step("e_mret");
    mret_i = 1'b0; gie_i = 1'b1; irq_req_i = '0;
    step("e_end");

    // Reset during service
    irq_req_i = 16'h0002;
    step("f_take");
    rst_i = 1'b0;
    step("f_rst");
    #1 check("f.busy", 32'(busy_o), 32'd0);
    check("f.ack", 32'(irq_ack_o), 32'd0);
    check("f.irq", 32'(irq_o), 32'd0);
    check("f.ret", 32'(irq_ret_o), 32'd0);
    check("f.cause", irq_cause_o, 32'h0);
    step("f_rst_hold");
    rst_i = 1'b1;
    #1 check("f.retake", 32'(irq_o), 32'd1);
    check("f.recause", irq_cause_o, 32'h8000_0011);
    step("f_take2");
    mret_i = 1'b1;
    step("f_mret");
    mret_i = 1'b0; irq_req_i = '0;
    step("f_idle");

`ifdef IRQ_RR_EN
    // Round-robin alternation with lines 0 and 1 held
    rst_i = 1'b0;
    step("g_rst");
    rst_i = 1'b1; irq_req_i = 16'h0003; mie_i = 16'hFFFF;
    for (int g = 0; g < 3; g++) begin
      #1 check("g.rr_cause", irq_cause_o, 32'h8000_0010 + 32'(g % 2));
      step("g_take");
      mret_i = 1'b1;
      step("g_mret");
      mret_i = 1'b0;
    end
    irq_req_i = '0;
    step("g_idle");
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_i       = ($urandom_range(0, 63) != 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      exception_i = ($urandom_range(0, 7) == 0);
      mret_i      = ($urandom_range(0, 3) == 0);
      gie_i       = ($urandom_range(0, 7) != 0);
      mie_i       = IRQ_NUM'($urandom);
      irq_req_i   = IRQ_NUM'($urandom & $urandom & $urandom);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
